// File: rtl/bp_fe_icache_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// bp_fe_icache_req_arbiter_if
//
// Purpose: groups the demand requester, the prefetch requester, the shared
// cache-engine port and the credit status of the I-cache request arbiter
// into one bundle.
//
// Signal summary (direction as seen by the arbiter, modport slave):
//   demand_req_i / demand_v_i / demand_ready_and_o : demand-miss requester
//   pf_req_i / pf_v_i / pf_ready_and_o             : next-line prefetcher
//   cache_req_o / cache_req_v_o / cache_req_ready_and_i : engine port
//   cache_req_pf_o        : held request originated from the prefetcher
//   cache_req_complete_i  : returns one credit per asserted cycle
//   flush_i               : discards prefetch traffic
//   credits_full_o / credits_empty_o : credit counter status
//
// Modport master is the environment side (requesters plus cache engine).
// ---------------------------------------------------------------------------
interface bp_fe_icache_req_arbiter_if #(
    parameter int req_width_p = 64
);
    logic [req_width_p-1:0] demand_req_i;
    logic                   demand_v_i;
    logic                   demand_ready_and_o;

    logic [req_width_p-1:0] pf_req_i;
    logic                   pf_v_i;
    logic                   pf_ready_and_o;

    logic [req_width_p-1:0] cache_req_o;
    logic                   cache_req_v_o;
    logic                   cache_req_ready_and_i;
    logic                   cache_req_pf_o;
    logic                   cache_req_complete_i;

    logic                   flush_i;
    logic                   credits_full_o;
    logic                   credits_empty_o;

    modport slave (
        input  demand_req_i, demand_v_i,
        output demand_ready_and_o,
        input  pf_req_i, pf_v_i,
        output pf_ready_and_o,
        output cache_req_o, cache_req_v_o, cache_req_pf_o,
        input  cache_req_ready_and_i, cache_req_complete_i,
        input  flush_i,
        output credits_full_o, credits_empty_o
    );

    modport master (
        output demand_req_i, demand_v_i,
        input  demand_ready_and_o,
        output pf_req_i, pf_v_i,
        input  pf_ready_and_o,
        input  cache_req_o, cache_req_v_o, cache_req_pf_o,
        output cache_req_ready_and_i, cache_req_complete_i,
        output flush_i,
        input  credits_full_o, credits_empty_o
    );
endinterface

// File: rtl/bp_fe_icache_req_arbiter.sv
// ---------------------------------------------------------------------------
// bp_fe_icache_req_arbiter
//
// Purpose: arbitrates between the front-end demand-miss requester and the
// next-line prefetcher for a single credit-limited cache-engine request
// port. One request is held at a time (IDLE / SEND FSM); demand wins by
// default, prefetch traffic can be flushed, and a credit counter limits the
// number of requests outstanding at the engine.
//
// Ports:
//   clk_i    : single clock
//   reset_i  : synchronous, active-high reset
//   bus      : bp_fe_icache_req_arbiter_if.slave (requesters, engine port,
//              flush, credit status)
//
// Parameters:
//   req_width_p    : opaque request payload width
//   credits_p      : maximum requests outstanding at the engine
//   starve_limit_p : consecutive prefetch losses before a forced grant
//
// Build option: define BP_FE_ARB_STARVE_EN to add the prefetch starvation
// counter and force grant. Without it, demand has strict priority.
// ---------------------------------------------------------------------------
module bp_fe_icache_req_arbiter #(
    parameter int req_width_p    = 64,
    parameter int credits_p      = 4,
    parameter int starve_limit_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    bp_fe_icache_req_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(credits_p + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_count;
    logic [req_width_p-1:0] r_req;
    logic                   r_pf;

    logic w_valid;
    logic w_hs;
    logic w_window;
    logic w_dem_ready;
    logic w_pf_ready;
    logic w_dem_acc;
    logic w_pf_acc;
    logic w_accept;
    logic w_force;

    // -----------------------------------------------------------------------
    // Optional starvation protection
    // -----------------------------------------------------------------------
`ifdef BP_FE_ARB_STARVE_EN
    localparam int STARVE_W = $clog2(starve_limit_p + 1);

    logic [STARVE_W-1:0] r_starve;
    logic                w_starve_hit;

    assign w_starve_hit = (r_starve == STARVE_W'(starve_limit_p));
    // Only block demand when a prefetch is actually there to take the slot;
    // a flush would refuse the prefetch anyway.
    assign w_force = w_starve_hit & bus.pf_v_i & ~bus.flush_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_starve <= '0;
        end else if (w_pf_acc || bus.flush_i) begin
            r_starve <= '0;
        end else if (bus.pf_v_i && w_dem_acc && !w_starve_hit) begin
            r_starve <= r_starve + STARVE_W'(1);
        end
    end
`else
    assign w_force = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    w_state_next = w_accept ? ST_SEND : ST_IDLE;
                end else if (bus.flush_i && r_pf) begin
                    // Held prefetch is dropped; it never reached the engine,
                    // so no credit is touched.
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs, accept window and requester readies
    // -----------------------------------------------------------------------
    always_comb begin
        w_valid     = 1'b0;
        w_window    = 1'b0;
        w_dem_ready = 1'b0;
        w_pf_ready  = 1'b0;
        if (!reset_i) begin
            w_valid = (r_state == ST_SEND);
            // A new request may be captured when the holding slot is free or
            // is being emptied this cycle, and the request already held still
            // leaves room under the credit limit.
            w_window = (!w_valid || bus.cache_req_ready_and_i) &&
                       ((int'(r_count) + int'(w_valid)) < credits_p);
            w_dem_ready = w_window & ~w_force;
            w_pf_ready  = w_window & ~bus.flush_i & (~bus.demand_v_i | w_force);
        end
    end

    assign w_hs      = w_valid & bus.cache_req_ready_and_i;
    assign w_dem_acc = bus.demand_v_i & w_dem_ready;
    assign w_pf_acc  = bus.pf_v_i & w_pf_ready;
    // The ready terms make these two mutually exclusive.
    assign w_accept  = w_dem_acc | w_pf_acc;

    // -----------------------------------------------------------------------
    // Held request register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_req <= '0;
            r_pf  <= 1'b0;
        end else if (w_accept) begin
            r_req <= w_dem_acc ? bus.demand_req_i : bus.pf_req_i;
            r_pf  <= w_pf_acc;
        end
    end

    // -----------------------------------------------------------------------
    // Credit counter: +1 per handshake, -1 per complete, never below zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (w_hs && !bus.cache_req_complete_i) begin
            r_count <= r_count + CNT_W'(1);
        end else if (!w_hs && bus.cache_req_complete_i && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Output drive (all forced to their idle values while reset_i is high)
    // -----------------------------------------------------------------------
    assign bus.cache_req_v_o      = w_valid;
    assign bus.cache_req_o        = reset_i ? '0 : r_req;
    assign bus.cache_req_pf_o     = w_valid & r_pf;
    assign bus.demand_ready_and_o = w_dem_ready;
    assign bus.pf_ready_and_o     = w_pf_ready;
    assign bus.credits_full_o     = ~reset_i & (r_count == CNT_W'(credits_p));
    assign bus.credits_empty_o    = reset_i | (r_count == '0);

endmodule

// File: tb/tb_bp_fe_icache_req_arbiter.sv
module tb_bp_fe_icache_req_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bp_fe_icache_req_arbiter_if #(.req_width_p(64)) bus ();

    bp_fe_icache_req_arbiter #(
        .req_width_p   (64),
        .credits_p     (4),
        .starve_limit_p(8)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.demand_req_i          = '0;
        bus.demand_v_i            = 1'b0;
        bus.pf_req_i              = '0;
        bus.pf_v_i                = 1'b0;
        bus.cache_req_ready_and_i = 1'b0;
        bus.cache_req_complete_i  = 1'b0;
        bus.flush_i               = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.demand_v_i = 1'b1;
        bus.pf_v_i     = 1'b1;
        cyc();
        cyc();
        settle();
        checks++; if (bus.cache_req_v_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.cache_req_v_o); end
        checks++; if (bus.demand_ready_and_o !== 1'b0) begin failures++; $display("FAIL reset_dem_ready: got %b want 0", bus.demand_ready_and_o); end
        checks++; if (bus.pf_ready_and_o !== 1'b0) begin failures++; $display("FAIL reset_pf_ready: got %b want 0", bus.pf_ready_and_o); end
        checks++; if (bus.cache_req_pf_o !== 1'b0) begin failures++; $display("FAIL reset_pf_flag: got %b want 0", bus.cache_req_pf_o); end
        checks++; if (bus.credits_empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", bus.credits_empty_o); end
        checks++; if (bus.credits_full_o !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", bus.credits_full_o); end
        checks++; if (bus.cache_req_o !== 64'h0) begin failures++; $display("FAIL reset_req: got %h want 0", bus.cache_req_o); end
        bus.demand_v_i = 1'b0;
        bus.pf_v_i     = 1'b0;
        rst = 1'b0;
        settle();
        checks++; if (bus.demand_ready_and_o !== 1'b1) begin failures++; $display("FAIL post_reset_dem_ready: got %b want 1", bus.demand_ready_and_o); end
        $display("test_reset: done");
    endtask

    task automatic test_single_demand();
        bus.demand_req_i          = 64'hA5;
        bus.demand_v_i            = 1'b1;
        bus.cache_req_ready_and_i = 1'b1;
        settle();
        checks++; if (bus.demand_ready_and_o !== 1'b1) begin failures++; $display("FAIL single_dem_ready: got %b want 1", bus.demand_ready_and_o); end
        cyc();
        bus.demand_v_i   = 1'b0;
        bus.demand_req_i = '0;
        checks++; if (bus.cache_req_v_o !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", bus.cache_req_v_o); end
        checks++; if (bus.cache_req_o !== 64'hA5) begin failures++; $display("FAIL single_payload: got %h want a5", bus.cache_req_o); end
        checks++; if (bus.cache_req_pf_o !== 1'b0) begin failures++; $display("FAIL single_pf_flag: got %b want 0", bus.cache_req_pf_o); end
        $display("test_single_demand: issued payload=%h", bus.cache_req_o);
        cyc();
        checks++; if (bus.cache_req_v_o !== 1'b0) begin failures++; $display("FAIL single_idle: got %b want 0", bus.cache_req_v_o); end
        checks++; if (dut.r_count !== 3'd1) begin failures++; $display("FAIL single_count: got %0d want 1", dut.r_count); end
        checks++; if (bus.credits_empty_o !== 1'b0) begin failures++; $display("FAIL single_empty: got %b want 0", bus.credits_empty_o); end
        bus.cache_req_complete_i = 1'b1;
        cyc();
        bus.cache_req_complete_i  = 1'b0;
        bus.cache_req_ready_and_i = 1'b0;
        checks++; if (dut.r_count !== 3'd0) begin failures++; $display("FAIL single_complete_count: got %0d want 0", dut.r_count); end
    endtask

    task automatic test_credit_exhaustion();
        bus.cache_req_ready_and_i = 1'b1;
        bus.demand_v_i            = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.demand_req_i = 64'h100 + 64'(i);
            cyc();
            checks++;
            if (bus.cache_req_v_o !== 1'b1 || bus.cache_req_o !== (64'h100 + 64'(i))) begin
                failures++;
                $display("FAIL exhaust_issue%0d: got v=%b req=%h want v=1 req=%h", i, bus.cache_req_v_o, bus.cache_req_o, 64'h100 + 64'(i));
            end
            $display("test_credit_exhaustion: issue %0d payload=%h", i, bus.cache_req_o);
        end
        cyc();
        checks++; if (bus.credits_full_o !== 1'b1) begin failures++; $display("FAIL exhaust_full: got %b want 1", bus.credits_full_o); end
        checks++; if (bus.demand_ready_and_o !== 1'b0) begin failures++; $display("FAIL exhaust_dem_ready: got %b want 0", bus.demand_ready_and_o); end
        checks++; if (bus.cache_req_v_o !== 1'b0) begin failures++; $display("FAIL exhaust_valid: got %b want 0", bus.cache_req_v_o); end
        checks++; if (dut.r_count !== 3'd4) begin failures++; $display("FAIL exhaust_count: got %0d want 4", dut.r_count); end
        bus.cache_req_complete_i = 1'b1;
        cyc();
        bus.cache_req_complete_i = 1'b0;
        bus.demand_v_i           = 1'b0;
        settle();
        checks++; if (bus.demand_ready_and_o !== 1'b1) begin failures++; $display("FAIL exhaust_ready_back: got %b want 1", bus.demand_ready_and_o); end
        checks++; if (bus.credits_full_o !== 1'b0) begin failures++; $display("FAIL exhaust_full_clear: got %b want 0", bus.credits_full_o); end
        checks++; if (dut.r_count !== 3'd3) begin failures++; $display("FAIL exhaust_count_after: got %0d want 3", dut.r_count); end
        bus.cache_req_complete_i = 1'b1;
        repeat (3) cyc();
        bus.cache_req_complete_i  = 1'b0;
        bus.cache_req_ready_and_i = 1'b0;
        checks++; if (dut.r_count !== 3'd0) begin failures++; $display("FAIL exhaust_drain: got %0d want 0", dut.r_count); end
    endtask

    task automatic test_complete_overlap();
        bus.demand_req_i          = 64'h55;
        bus.demand_v_i            = 1'b1;
        bus.cache_req_ready_and_i = 1'b1;
        cyc();
        cyc();
        bus.demand_v_i = 1'b0;
        cyc();
        checks++; if (dut.r_count !== 3'd2) begin failures++; $display("FAIL overlap_pre_count: got %0d want 2", dut.r_count); end
        bus.demand_req_i          = 64'h77;
        bus.demand_v_i            = 1'b1;
        bus.cache_req_ready_and_i = 1'b0;
        cyc();
        bus.demand_v_i            = 1'b0;
        bus.cache_req_ready_and_i = 1'b1;
        bus.cache_req_complete_i  = 1'b1;
        settle();
        checks++; if (bus.cache_req_v_o !== 1'b1) begin failures++; $display("FAIL overlap_valid: got %b want 1", bus.cache_req_v_o); end
        cyc();
        bus.cache_req_ready_and_i = 1'b0;
        bus.cache_req_complete_i  = 1'b0;
        checks++; if (dut.r_count !== 3'd2) begin failures++; $display("FAIL overlap_count: got %0d want 2", dut.r_count); end
        checks++; if (bus.cache_req_v_o !== 1'b0) begin failures++; $display("FAIL overlap_idle: got %b want 0", bus.cache_req_v_o); end
        $display("test_complete_overlap: handshake+complete count=%0d", dut.r_count);
        bus.cache_req_complete_i = 1'b1;
        cyc();
        cyc();
        cyc();
        bus.cache_req_complete_i = 1'b0;
        checks++; if (dut.r_count !== 3'd0) begin failures++; $display("FAIL underflow_count: got %0d want 0", dut.r_count); end
        checks++; if (bus.credits_empty_o !== 1'b1) begin failures++; $display("FAIL underflow_empty: got %b want 1", bus.credits_empty_o); end
        checks++; if (bus.credits_full_o !== 1'b0) begin failures++; $display("FAIL underflow_full: got %b want 0", bus.credits_full_o); end
    endtask

    task automatic test_flush();
        bus.cache_req_ready_and_i = 1'b0;
        bus.pf_req_i = 64'h5F;
        bus.pf_v_i   = 1'b1;
        settle();
        checks++; if (bus.pf_ready_and_o !== 1'b1) begin failures++; $display("FAIL flush_pf_ready: got %b want 1", bus.pf_ready_and_o); end
        cyc();
        bus.pf_v_i = 1'b0;
        checks++;
        if (bus.cache_req_v_o !== 1'b1 || bus.cache_req_pf_o !== 1'b1 || bus.cache_req_o !== 64'h5F) begin
            failures++;
            $display("FAIL flush_pf_held: got v=%b pf=%b req=%h want v=1 pf=1 req=5f", bus.cache_req_v_o, bus.cache_req_pf_o, bus.cache_req_o);
        end
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;
        checks++; if (bus.cache_req_v_o !== 1'b0) begin failures++; $display("FAIL flush_drop: got %b want 0", bus.cache_req_v_o); end
        checks++; if (dut.r_count !== 3'd0) begin failures++; $display("FAIL flush_count: got %0d want 0", dut.r_count); end
        $display("test_flush: held prefetch dropped");
        bus.flush_i = 1'b1;
        bus.pf_v_i  = 1'b1;
        settle();
        checks++; if (bus.pf_ready_and_o !== 1'b0) begin failures++; $display("FAIL flush_blocks_pf: got %b want 0", bus.pf_ready_and_o); end
        cyc();
        bus.pf_v_i  = 1'b0;
        bus.flush_i = 1'b0;
        checks++; if (bus.cache_req_v_o !== 1'b0) begin failures++; $display("FAIL flush_no_accept: got %b want 0", bus.cache_req_v_o); end
        bus.demand_req_i = 64'hD1;
        bus.demand_v_i   = 1'b1;
        cyc();
        bus.demand_v_i = 1'b0;
        bus.flush_i    = 1'b1;
        cyc();
        checks++;
        if (bus.cache_req_v_o !== 1'b1 || bus.cache_req_o !== 64'hD1 || bus.cache_req_pf_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_keeps_demand: got v=%b req=%h pf=%b want v=1 req=d1 pf=0", bus.cache_req_v_o, bus.cache_req_o, bus.cache_req_pf_o);
        end
        bus.flush_i               = 1'b0;
        bus.cache_req_ready_and_i = 1'b1;
        cyc();
        bus.cache_req_ready_and_i = 1'b0;
        checks++; if (bus.cache_req_v_o !== 1'b0) begin failures++; $display("FAIL flush_demand_sent: got %b want 0", bus.cache_req_v_o); end
        checks++; if (dut.r_count !== 3'd1) begin failures++; $display("FAIL flush_demand_count: got %0d want 1", dut.r_count); end
        $display("test_flush: held demand issued under flush");
        bus.cache_req_complete_i = 1'b1;
        cyc();
        bus.cache_req_complete_i = 1'b0;
    endtask

    task automatic test_starvation();
        int first_pf;
        int exp_first;
        logic exp_dem_ready8;
`ifdef BP_FE_ARB_STARVE_EN
        exp_first      = 9;
        exp_dem_ready8 = 1'b0;
`else
        exp_first      = 0;
        exp_dem_ready8 = 1'b1;
`endif
        first_pf = 0;
        bus.demand_req_i          = 64'hDD;
        bus.pf_req_i              = 64'hEE;
        bus.demand_v_i            = 1'b1;
        bus.pf_v_i                = 1'b1;
        bus.cache_req_ready_and_i = 1'b1;
        bus.cache_req_complete_i  = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            if (n == 8) begin
                checks++; if (bus.demand_ready_and_o !== exp_dem_ready8) begin failures++; $display("FAIL starve_dem_ready: got %b want %b", bus.demand_ready_and_o, exp_dem_ready8); end
            end
            if (first_pf == 0 && bus.cache_req_v_o === 1'b1 && bus.cache_req_pf_o === 1'b1) begin
                first_pf = n;
                checks++; if (bus.cache_req_o !== 64'hEE) begin failures++; $display("FAIL starve_pf_payload: got %h want ee", bus.cache_req_o); end
            end
        end
        checks++; if (first_pf != exp_first) begin failures++; $display("FAIL starve_grant: got accept %0d want %0d", first_pf, exp_first); end
        $display("test_starvation: first prefetch grant at accept %0d", first_pf);
        bus.demand_v_i = 1'b0;
        bus.pf_v_i     = 1'b0;
        cyc();
        bus.cache_req_complete_i  = 1'b0;
        bus.cache_req_ready_and_i = 1'b0;
        checks++; if (bus.cache_req_v_o !== 1'b0) begin failures++; $display("FAIL starve_idle: got %b want 0", bus.cache_req_v_o); end
        checks++; if (dut.r_count !== 3'd0) begin failures++; $display("FAIL starve_count: got %0d want 0", dut.r_count); end
    endtask

    task automatic test_reset_mid();
        bus.demand_req_i          = 64'h33;
        bus.demand_v_i            = 1'b1;
        bus.cache_req_ready_and_i = 1'b1;
        repeat (4) cyc();
        bus.demand_v_i            = 1'b0;
        bus.cache_req_ready_and_i = 1'b0;
        checks++; if (bus.cache_req_v_o !== 1'b1) begin failures++; $display("FAIL mid_pre_valid: got %b want 1", bus.cache_req_v_o); end
        checks++; if (dut.r_count !== 3'd3) begin failures++; $display("FAIL mid_pre_count: got %0d want 3", dut.r_count); end
        rst = 1'b1;
        settle();
        checks++; if (bus.cache_req_v_o !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b want 0", bus.cache_req_v_o); end
        cyc();
        rst = 1'b0;
        checks++; if (bus.cache_req_v_o !== 1'b0) begin failures++; $display("FAIL mid_after_valid: got %b want 0", bus.cache_req_v_o); end
        checks++; if (bus.credits_empty_o !== 1'b1) begin failures++; $display("FAIL mid_after_empty: got %b want 1", bus.credits_empty_o); end
        checks++; if (dut.r_count !== 3'd0) begin failures++; $display("FAIL mid_after_count: got %0d want 0", dut.r_count); end
        settle();
        checks++; if (bus.demand_ready_and_o !== 1'b1) begin failures++; $display("FAIL mid_after_ready: got %b want 1", bus.demand_ready_and_o); end
        $display("test_reset_mid: held request and credits discarded");
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_demand();
        test_credit_exhaustion();
        test_complete_overlap();
        test_flush();
        test_starvation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_fe_icache_req_arbiter.md
BP_FE_ICACHE_REQ_ARBITER -- requirements
Module: bp_fe_icache_req_arbiter

Interface
REQ-001 SHALL have parameter req_width_p, default 64; opaque cache request payload width.
REQ-002 SHALL have parameter credits_p, default 4; maximum number of requests outstanding at the cache engine.
REQ-003 SHALL have parameter starve_limit_p, default 8; consecutive prefetch-loss cycles before a forced prefetch grant.
REQ-004 SHALL have port clk_i, input, 1 bit; the single clock.
REQ-005 SHALL have port reset_i, input, 1 bit; synchronous, active-high reset.
REQ-006 SHALL have ports demand_req_i (input, req_width_p), demand_v_i (input, 1) and demand_ready_and_o (output, 1); the demand-miss requester.
REQ-007 SHALL have ports pf_req_i (input, req_width_p), pf_v_i (input, 1) and pf_ready_and_o (output, 1); the next-line prefetch requester.
REQ-008 SHALL have ports cache_req_o (output, req_width_p), cache_req_v_o (output, 1) and cache_req_ready_and_i (input, 1); the shared engine port.
REQ-009 SHALL have port cache_req_pf_o, output, 1 bit; asserted when the held request came from the prefetcher.
REQ-010 SHALL have port cache_req_complete_i, input, 1 bit; returns one credit per asserted cycle.
REQ-011 SHALL have port flush_i, input, 1 bit; discards prefetch traffic.
REQ-012 SHALL have ports credits_full_o and credits_empty_o, both outputs of 1 bit.

Function
REQ-013 SHALL implement a two-state FSM: IDLE has no held request; SEND holds one request with cache_req_v_o=1.
REQ-014 SHALL define a handshake as cache_req_v_o & cache_req_ready_and_i.
REQ-015 SHALL keep cache_req_o and cache_req_pf_o stable while in SEND until the handshake occurs.
REQ-016 SHALL define the accept window as (IDLE, or SEND with a handshake this cycle) & (count + (state==SEND)) < credits_p.
- Ready outputs may therefore depend combinationally on cache_req_ready_and_i.
REQ-017 SHALL assert demand_ready_and_o whenever the accept window is open and the prefetch is not being force-granted.
REQ-018 SHALL assert pf_ready_and_o only when all of the following hold: the accept window is open, flush_i=0, and either demand_v_i=0 or a force grant is active.
REQ-019 SHALL capture an accepted request and present it on cache_req_o the next cycle, entering or staying in SEND; latency is 1 cycle.
REQ-020 SHALL return to IDLE after a handshake with no new accept in the same cycle.
REQ-021 SHALL update the credit counter count (0..credits_p) as follows:
- +1 on a handshake;
- -1 on cache_req_complete_i;
- unchanged when both occur in the same cycle;
- a complete at count=0 is ignored (no underflow).
REQ-022 SHALL drive credits_full_o = (count==credits_p) and credits_empty_o = (count==0).
REQ-023 SHALL, on flush_i in SEND holding a prefetch without a handshake that cycle, drop the held prefetch and go to IDLE, with count unchanged.
REQ-024 SHALL never drop a held demand request on flush_i.
REQ-025 SHALL give flush_i priority over a same-cycle accept of prefetch only; a demand accept in the same cycle proceeds normally.

Reset
REQ-026 SHALL, on reset_i, clear the following: state=IDLE, count=0, starve counter=0.
REQ-027 SHALL, during reset, drive cache_req_v_o=0, demand_ready_and_o=0, pf_ready_and_o=0, cache_req_pf_o=0, credits_empty_o=1, credits_full_o=0 and cache_req_o=0.
REQ-028 SHALL, on reset mid-operation, discard any held request and all credits without emitting a handshake.

Configuration
REQ-029 SHALL support the macro BP_FE_ARB_STARVE_EN.
- Defined: a starve counter increments each cycle pf_v_i=1 while demand wins the accept, and clears on a prefetch accept or flush_i.
- Defined: at starve_limit_p, the next accept window grants the prefetch over demand (force grant).
- Undefined: strict demand priority applies, and no starve counter exists.

Verification
REQ-030 SHALL cover single demand: demand_v_i=1, payload 0xA5, ready_and=1 -> cache_req_v_o=1 with 0xA5 one cycle later, then count=1.
REQ-031 SHALL cover credit exhaustion: 4 back-to-back demand handshakes with no completes -> credits_full_o=1, demand_ready_and_o=0; one complete -> ready reasserts the next cycle.
REQ-032 SHALL cover simultaneous handshake and complete at count=2 -> count stays 2; complete at count=0 -> count stays 0.
REQ-033 SHALL cover flush of a held prefetch with ready_and=0, flush_i=1 -> cache_req_v_o=0 the next cycle, count unchanged; a held demand under the same flush -> still issued.
REQ-034 SHALL cover starvation with BP_FE_ARB_STARVE_EN: demand and pf both valid continuously with ready_and=1 -> the prefetch is granted within 9 accepts, cache_req_pf_o=1; without the macro -> the prefetch is never granted.
REQ-035 SHALL cover reset asserted in SEND with count=3 -> the next cycle shows cache_req_v_o=0, credits_empty_o=1.
